// File: rtl/bin_loader.sv
// bin_loader
//   Copies one bin from the bin manager's memories into the SAT core.
//   It reads the bin's clause words from clause RAM and writes them into the
//   core clause array. It then reads the bin's variable-state words from
//   var-state RAM and writes them into the core variable-state registers.
//   Finally it pulses done_load_o.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   start_load_i        one-cycle load request, accepted only when idle
//   bin_id_i            bin to load, sampled together with start_load_i
//   busy_o              load in progress (cycle after start .. done cycle)
//   done_load_o         one-cycle completion pulse
//   c_rd_en_o/addr_o    clause RAM read port; data returns next cycle
//   c_rd_data_i         clause RAM read data
//   vs_rd_en_o/addr_o   var-state RAM read port; data returns next cycle
//   vs_rd_data_i        var-state RAM read data
//   wr_carray_o         one-hot clause-row write strobe to the core
//   clause_o            clause word to the core (0 when not writing)
//   wr_var_states_o     one-hot variable write strobe to the core
//   vars_states_o       var-state bus; only the strobed slice is non-zero
module bin_loader #(
    parameter int NUM_CLAUSES_A_BIN     = 8,
    parameter int NUM_VARS_A_BIN        = 8,
    parameter int WIDTH_BIN_ID          = 10,
    parameter int WIDTH_VAR_STATES      = 11,
    parameter int ADDR_WIDTH_CLAUSES    = 9,
    parameter int ADDR_WIDTH_VAR_STATES = 9
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_load_i,
    input  logic [WIDTH_BIN_ID-1:0]                    bin_id_i,
    output logic                                       busy_o,
    output logic                                       done_load_o,
    output logic                                       c_rd_en_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0]              c_rd_addr_o,
    input  logic [2*NUM_VARS_A_BIN-1:0]                c_rd_data_i,
    output logic                                       vs_rd_en_o,
    output logic [ADDR_WIDTH_VAR_STATES-1:0]           vs_rd_addr_o,
    input  logic [WIDTH_VAR_STATES-1:0]                vs_rd_data_i,
    output logic [NUM_CLAUSES_A_BIN-1:0]               wr_carray_o,
    output logic [2*NUM_VARS_A_BIN-1:0]                clause_o,
    output logic [NUM_VARS_A_BIN-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_o
);

    localparam int MAX_N = (NUM_CLAUSES_A_BIN > NUM_VARS_A_BIN) ?
                           NUM_CLAUSES_A_BIN : NUM_VARS_A_BIN;
    localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(NUM_CLAUSES_A_BIN - 1);
    localparam logic [IDX_W-1:0] LAST_V = IDX_W'(NUM_VARS_A_BIN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_C  = 3'd1,
        RD_V  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [WIDTH_BIN_ID-1:0] bin_q, bin_nx;

    // Write pipeline: a read issued in cycle t becomes a core write in t+1.
    // The index of that read travels with its valid bit.
    logic                    c_vld, v_vld;
    logic [IDX_W-1:0]        wr_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= '0;
            bin_q  <= '0;
            c_vld  <= 1'b0;
            v_vld  <= 1'b0;
            wr_idx <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            bin_q  <= bin_nx;
            c_vld  <= c_rd_en_o;
            v_vld  <= vs_rd_en_o;
            wr_idx <= idx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        bin_nx      = bin_q;
        busy_o      = 1'b1;
        done_load_o = 1'b0;
        c_rd_en_o   = 1'b0;
        vs_rd_en_o  = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_load_i) begin
                    bin_nx   = bin_id_i;
                    idx_nx   = '0;
                    state_nx = RD_C;
                end
            end
            RD_C: begin
                c_rd_en_o = 1'b1;
                if (idx == LAST_C) begin
                    idx_nx   = '0;
                    state_nx = RD_V;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            RD_V: begin
                vs_rd_en_o = 1'b1;
                if (idx == LAST_V) begin
                    idx_nx   = '0;
                    state_nx = DRAIN;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            // last var-state write lands here
            DRAIN: state_nx = DONE;
            DONE: begin
                done_load_o = 1'b1;
                state_nx    = IDLE;
            end
            default: begin
                busy_o   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Address = bin*N + idx. It is formed wide and then truncated, so large
    // bin ids wrap modulo the RAM size. Addresses read 0 while not reading.
    assign c_rd_addr_o  = c_rd_en_o ?
        ADDR_WIDTH_CLAUSES'(32'(bin_q) * 32'(NUM_CLAUSES_A_BIN) + 32'(idx)) : '0;
    assign vs_rd_addr_o = vs_rd_en_o ?
        ADDR_WIDTH_VAR_STATES'(32'(bin_q) * 32'(NUM_VARS_A_BIN) + 32'(idx)) : '0;

    assign clause_o = c_vld ? c_rd_data_i : '0;

    for (genvar r = 0; r < NUM_CLAUSES_A_BIN; r++) begin : g_row
        assign wr_carray_o[r] = c_vld && (wr_idx == IDX_W'(r));
    end

    for (genvar v = 0; v < NUM_VARS_A_BIN; v++) begin : g_var
        logic hit;
        assign hit                = v_vld && (wr_idx == IDX_W'(v));
        assign wr_var_states_o[v] = hit;
        assign vars_states_o[v*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] =
            hit ? vs_rd_data_i : '0;
    end

endmodule

// File: tb/tb_bin_loader.sv
// Directed bench for bin_loader. It uses behavioural clause and var-state RAMs
// with one-cycle read latency. Clause word at address a is 16'h0100+a. The
// var-state word at address a is 11'h010+a.
module tb_bin_loader;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int WV = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_load;
    logic [9:0]    bin_id;
    logic          busy, done_load;
    logic          c_rd_en, vs_rd_en;
    logic [8:0]    c_rd_addr, vs_rd_addr;
    logic [15:0]   c_rd_data;
    logic [10:0]   vs_rd_data;
    logic [7:0]    wr_carray, wr_var_states;
    logic [15:0]   clause;
    logic [87:0]   vars_states;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bin_loader dut (
        .clk            (clk),
        .rst            (rst),
        .start_load_i   (start_load),
        .bin_id_i       (bin_id),
        .busy_o         (busy),
        .done_load_o    (done_load),
        .c_rd_en_o      (c_rd_en),
        .c_rd_addr_o    (c_rd_addr),
        .c_rd_data_i    (c_rd_data),
        .vs_rd_en_o     (vs_rd_en),
        .vs_rd_addr_o   (vs_rd_addr),
        .vs_rd_data_i   (vs_rd_data),
        .wr_carray_o    (wr_carray),
        .clause_o       (clause),
        .wr_var_states_o(wr_var_states),
        .vars_states_o  (vars_states)
    );

    // RAM models: registered read, data held when not enabled
    initial begin
        c_rd_data  = '0;
        vs_rd_data = '0;
    end
    always @(posedge clk) begin
        if (c_rd_en)  c_rd_data  <= 16'h0100 + 16'(c_rd_addr);
        if (vs_rd_en) vs_rd_data <= 11'h010 + 11'(vs_rd_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"},  128'(busy),          128'(0));
        chk({tag, ".done"},  128'(done_load),     128'(0));
        chk({tag, ".c_en"},  128'(c_rd_en),       128'(0));
        chk({tag, ".c_ad"},  128'(c_rd_addr),     128'(0));
        chk({tag, ".v_en"},  128'(vs_rd_en),      128'(0));
        chk({tag, ".v_ad"},  128'(vs_rd_addr),    128'(0));
        chk({tag, ".wc"},    128'(wr_carray),     128'(0));
        chk({tag, ".cl"},    128'(clause),        128'(0));
        chk({tag, ".wv"},    128'(wr_var_states), 128'(0));
        chk({tag, ".vs"},    128'(vars_states),   128'(0));
    endtask

    // Starts a load in the current cycle (cycle 0). It checks cycles 1..18 and
    // returns in cycle 19 with start low. If inject is set, it raises start with
    // bin 5 in cycles 4 and 18; those starts must be ignored.
    task automatic run_load(input string tag, input int b, input bit inject);
        logic [7:0]  e_wc, e_wv;
        logic [15:0] e_cl;
        logic [87:0] e_vs;
        int          k;
        string       t;
        start_load = 1'b1;
        bin_id     = 10'(b);
        tick();
        for (int n = 1; n <= NC + NV + 2; n++) begin
            start_load = 1'b0;
            bin_id     = 10'h3FF;
            if (inject && (n == 4 || n == NC + NV + 2)) begin
                start_load = 1'b1;
                bin_id     = 10'd5;
            end
            t = $sformatf("%s@%0d", tag, n);
            chk({t, ".busy"}, 128'(busy),      128'(1));
            chk({t, ".done"}, 128'(done_load), 128'(n == NC + NV + 2));
            chk({t, ".c_en"}, 128'(c_rd_en),   128'(n >= 1 && n <= NC));
            if (n >= 1 && n <= NC)
                chk({t, ".c_ad"}, 128'(c_rd_addr), 128'((b*NC + n - 1) % 512));
            chk({t, ".v_en"}, 128'(vs_rd_en),  128'(n >= NC + 1 && n <= NC + NV));
            if (n >= NC + 1 && n <= NC + NV)
                chk({t, ".v_ad"}, 128'(vs_rd_addr), 128'((b*NV + n - NC - 1) % 512));
            e_wc = '0; e_cl = '0; e_wv = '0; e_vs = '0;
            if (n >= 2 && n <= NC + 1) begin
                k = n - 2;
                e_wc[k] = 1'b1;
                e_cl    = 16'h0100 + 16'((b*NC + k) % 512);
            end
            if (n >= NC + 2 && n <= NC + NV + 1) begin
                k = n - NC - 2;
                e_wv[k]         = 1'b1;
                e_vs[k*WV +: WV] = 11'h010 + 11'((b*NV + k) % 512);
            end
            chk({t, ".wc"}, 128'(wr_carray),     128'(e_wc));
            chk({t, ".cl"}, 128'(clause),        128'(e_cl));
            chk({t, ".wv"}, 128'(wr_var_states), 128'(e_wv));
            chk({t, ".vs"}, 128'(vars_states),   128'(e_vs));
            chk({t, ".oh"}, 128'($onehot0(wr_carray) && $onehot0(wr_var_states)), 128'(1));
            chk({t, ".ex"}, 128'(wr_carray != 0 && wr_var_states != 0), 128'(0));
            tick();
        end
        start_load = 1'b0;
        bin_id     = '0;
    endtask

    initial begin
        rst        = 1'b0;
        start_load = 1'b0;
        bin_id     = '0;
        tick();
        tick();
        check_zero("reset");

        rst = 1'b1;
        tick();
        check_zero("idle");

        // basic load, then an immediate back-to-back load of a wrapping bin
        run_load("basic", 0, 1'b0);
        run_load("b2b70", 70, 1'b0);
        check_zero("post70");

        // starts while busy (cycle 4) and in the DONE cycle (18) are ignored
        run_load("ign3", 3, 1'b1);
        check_zero("ign19");
        tick();
        check_zero("ign20");

        // reset in the middle of a load
        start_load = 1'b1;
        bin_id     = 10'd3;
        tick();
        start_load = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            chk($sformatf("mid@%0d.busy", n), 128'(busy), 128'(1));
            if (n == 6) rst = 1'b0;
            else tick();
        end
        tick();
        check_zero("rst7");
        rst = 1'b1;
        for (int n = 8; n <= 20; n++) begin
            tick();
            check_zero($sformatf("aband@%0d", n));
        end

        run_load("fresh", 0, 1'b0);
        check_zero("end");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
